seq_adder: RTL and testbench
============================

SEQ_ADDER -- requirements
Module: seq_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be >= 2.
REQ-002 Parameter DIGIT, default 4, bits added per clock; SHALL divide WIDTH exactly (STEPS = WIDTH/DIGIT).
REQ-003 Single clock domain; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 start  input  1  request; sampled only when ready to accept.
REQ-007 sub  input  1  0 = add, 1 = subtract (a - b); captured with start.
REQ-008 a, b  input  WIDTH  operands; captured with start.
REQ-009 c_in  input  1  carry-in for add mode; captured with start.
REQ-010 sum  output  WIDTH  result, valid from done until next accepted start.
REQ-011 c_out  output  1  carry-out (add) / not-borrow (sub).
REQ-012 overflow  output  1  two's-complement overflow flag (see Configuration).
REQ-013 busy  output  1  high while the operation is in progress.
REQ-014 done  output  1  one-cycle pulse marking result valid.

Function
REQ-015 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-016 IDLE: start=1 -> capture a, b, sub, c_in; counter=0; go RUN; else stay.
REQ-017 Carry-in at capture: add = c_in; sub = 1 with b inverted, and c_in ignored.
REQ-018 RUN: each edge adds the lowest DIGIT bits of the operand registers plus the running carry, shifts the DIGIT result bits into sum from MSB side, shifts operands right by DIGIT, and increments the counter.
REQ-019 RUN -> DONE on the edge that processes step STEPS-1; c_out = final carry.
REQ-020 Latency: start sampled at edge E0 -> done high in the cycle following edge E0+STEPS; busy high from E0 through E0+STEPS.
REQ-021 DONE lasts exactly one cycle; done=1, busy=0; start=1 in DONE is accepted as in IDLE (back-to-back operation, no bubble); else -> IDLE.
REQ-022 start while in RUN is ignored; operands in flight are unaffected.
REQ-023 sum, c_out, overflow hold their values from DONE until the next accepted start; during RUN they are undefined to the user and are not checked.
REQ-024 Arithmetic is modulo 2^WIDTH; no saturation.

Reset
REQ-025 rst=1 at any time forces IDLE immediately; sum=0, c_out=0, overflow=0, busy=0, done=0, counter and operand registers 0.
REQ-026 Reset during RUN aborts the operation with no done pulse; first start after reset release behaves as from power-up.

Configuration
REQ-027 Macro SEQ_ADDER_OVERFLOW_EN defined: overflow = carry into MSB XOR carry out of MSB, registered at DONE with the result.
REQ-028 Macro not defined: overflow port present and tied to 0; no overflow logic synthesised.

Structure
REQ-029 Package seq_adder_pkg holds the FSM state typedef (IDLE, RUN, DONE) and a function computing STEPS and counter width from WIDTH and DIGIT.
REQ-030 Sub-module digit_adder: combinational DIGIT-bit ripple-carry adder (a, b, cin -> s, cout, plus carry into MSB for overflow), instantiated once.

Verification (WIDTH=16, DIGIT=4, STEPS=4)
REQ-031 Add: a=0xFFFF, b=0x0001, c_in=0, sub=0 -> done 4 cycles after start edge, sum=0x0000, c_out=1, busy high exactly 4 cycles.
REQ-032 Subtract: a=0x0005, b=0x0007, sub=1, c_in=1 (ignored) -> sum=0xFFFE, c_out=0.
REQ-033 Overflow (macro defined): a=0x7FFF, b=0x0001, add -> sum=0x8000, overflow=1, c_out=0; macro undefined -> overflow=0.
REQ-034 start pulsed again 2 cycles into RUN with different operands -> ignored; original result delivered; start held in DONE -> second operation runs back-to-back, second done 4 cycles later.
REQ-035 rst asserted 2 cycles into RUN -> all outputs 0 asynchronously, no done; fresh a=0x1234, b=0x1111 afterwards -> sum=0x2345.
REQ-036 Random sweep (>=1000 ops, both modes, random c_in) against reference model of a+b+c_in / a-b.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder.
//   state_t      : FSM state encoding (IDLE, RUN, DONE)
//   calc_steps   : number of digit steps for a WIDTH/DIGIT pair
//   calc_cnt_w   : step counter width (at least 1 bit)
package seq_adder_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t RUN  = 2'd1;
   localparam state_t DONE = 2'd2;

   function automatic int unsigned calc_steps(input int unsigned width,
                                              input int unsigned digit);
      return width / digit;
   endfunction

   function automatic int unsigned calc_cnt_w(input int unsigned width,
                                              input int unsigned digit);
      int unsigned steps;
      steps = width / digit;
      return (steps > 1) ? $clog2(steps) : 1;
   endfunction

endpackage

// File: rtl/seq_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder.
//   a, b  : digit operands
//   cin   : carry into bit 0
//   s     : digit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (used for signed overflow)
module digit_adder
   import seq_adder_pkg::*;
#(
   parameter int unsigned DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             c_msb
);

   // Ripple chain; cy[i] is the carry into bit i.
   always_comb begin
      logic [DIGIT:0] cy;
      cy    = '0;
      s     = '0;
      cy[0] = cin;
      for (int i = 0; i < int'(DIGIT); i++) begin
         s[i]    = a[i] ^ b[i] ^ cy[i];
         cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
      end
      cout  = cy[DIGIT];
      c_msb = cy[DIGIT-1];
   end

endmodule

// File: rtl/seq_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per clock over WIDTH/DIGIT
// steps, result shifted into sum from the MSB side.
//   clk, rst          : clock, asynchronous active-high reset
//   start, sub, c_in  : request, mode (1 = a - b), add-mode carry-in
//   a, b              : operands, captured when start is accepted
//   sum, c_out        : result and carry-out / not-borrow, held after done
//   overflow          : signed overflow; only built with SEQ_ADDER_OVERFLOW_EN
//   busy, done        : operation in progress / one-cycle result-valid pulse
module seq_adder
   import seq_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int unsigned      STEPS = calc_steps(WIDTH, DIGIT);
   localparam int unsigned      CNT_W = calc_cnt_w(WIDTH, DIGIT);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEPS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic [DIGIT-1:0] dig_s;
   logic             dig_cout;
   logic             dig_cmsb;
   logic             accept;
   logic             last_step;

   // Start is honoured in IDLE and DONE only, giving back-to-back operation.
   assign accept    = start && ((state == IDLE) || (state == DONE));
   assign last_step = (state == RUN) && (cnt_q == LAST);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (cnt_q == LAST) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   digit_adder #(
      .DIGIT (DIGIT)
   ) u_digit_adder (
      .a     (a_q[DIGIT-1:0]),
      .b     (b_q[DIGIT-1:0]),
      .cin   (carry_q),
      .s     (dig_s),
      .cout  (dig_cout),
      .c_msb (dig_cmsb)
   );

   // Operand capture, digit shifting and registered status outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum     <= '0;
         c_out   <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         busy <= (state_nxt == RUN);
         done <= (state_nxt == DONE);
         if (accept) begin
            // Subtract as a + ~b + 1; c_in has no effect in that mode.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : c_in;
            cnt_q   <= '0;
         end else if (state == RUN) begin
            sum     <= (sum >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            carry_q <= dig_cout;
            cnt_q   <= cnt_q + CNT_W'(1);
            if (last_step) c_out <= dig_cout;
         end
      end
   end

`ifdef SEQ_ADDER_OVERFLOW_EN
   // Signed overflow: carries into and out of the word MSB disagree.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)            overflow <= 1'b0;
      else if (last_step) overflow <= dig_cmsb ^ dig_cout;
   end
`else
   logic unused_c_msb;
   assign unused_c_msb = dig_cmsb;
   assign overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_seq_adder.sv
module tb_seq_adder;

   localparam int STEPS = 4;
`ifdef SEQ_ADDER_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sub = 1'b0;
   logic        c_in = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic [15:0] sum;
   logic        c_out;
   logic        overflow;
   logic        busy;
   logic        done;

   int tests = 0;
   int fails = 0;

   seq_adder #(.WIDTH(16), .DIGIT(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sum      (sum),
      .c_out    (c_out),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   task automatic model(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                        input logic xc, output logic [15:0] es, output logic eco,
                        output logic eov);
      int ua, ub, sa, sb, ci, full, sres;
      ua = int'(xa);
      ub = int'(xb);
      sa = int'($signed(xa));
      sb = int'($signed(xb));
      ci = xc ? 1 : 0;
      if (!xs) begin
         full = ua + ub + ci;
         eco  = (full >= 65536);
         sres = sa + sb + ci;
      end else begin
         full = ua - ub;
         eco  = (ua >= ub);
         sres = sa - sb;
      end
      es  = 16'(full);
      eov = OVF_EN && ((sres > 32767) || (sres < -32768));
   endtask

   // Entered at a negedge: present a request for one edge.
   task automatic launch(input logic [15:0] xa, input logic [15:0] xb, input logic xs,
                         input logic xc);
      a = xa; b = xb; sub = xs; c_in = xc; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Entered at the first negedge after the start edge; ends at the done negedge.
   task automatic op_check(input logic [15:0] es, input logic eco, input logic eov,
                           input int poke_k);
      for (int k = 1; k <= STEPS; k++) begin
         if (k == poke_k) begin
            a = 16'($urandom); b = 16'($urandom); sub = ~sub; c_in = ~c_in;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         check("busy_run", busy, 1);
         check("done_early", done, 0);
         @(negedge clk);
      end
      start = 1'b0;
      check("done_pulse", done, 1);
      check("busy_at_done", busy, 0);
      check("sum", sum, es);
      check("c_out", c_out, eco);
      check("overflow", overflow, eov);
   endtask

   // One cycle after done: back in IDLE with the result held.
   task automatic post_check(input logic [15:0] es, input logic eco, input logic eov);
      @(negedge clk);
      check("done_single", done, 0);
      check("busy_idle", busy, 0);
      check("sum_hold", sum, es);
      check("c_out_hold", c_out, eco);
      check("ovf_hold", overflow, eov);
   endtask

   initial begin
      logic [15:0] es;
      logic        eco, eov;
      logic [15:0] ra, rb;
      logic        rs, rc;

      // Reset state
      @(negedge clk);
      check("rst_sum", sum, 0);
      check("rst_c_out", c_out, 0);
      check("rst_ovf", overflow, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Add with wrap: FFFF + 1
      launch(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      op_check(16'h0000, 1'b1, 1'b0, 0);
      post_check(16'h0000, 1'b1, 1'b0);

      // Subtract with borrow; c_in ignored
      launch(16'h0005, 16'h0007, 1'b1, 1'b1);
      op_check(16'hFFFE, 1'b0, 1'b0, 0);
      post_check(16'hFFFE, 1'b0, 1'b0);

      // Signed overflow
      launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      op_check(16'h8000, 1'b0, OVF_EN, 0);
      post_check(16'h8000, 1'b0, OVF_EN);

      // Start during RUN ignored, then back-to-back start held in DONE
      launch(16'h1000, 16'h0234, 1'b0, 1'b0);
      op_check(16'h1234, 1'b0, 1'b0, 2);
      launch(16'h00FF, 16'h0F01, 1'b0, 1'b1);
      op_check(16'h1001, 1'b0, 1'b0, 0);
      post_check(16'h1001, 1'b0, 1'b0);

      // Reset two cycles into RUN
      launch(16'hAAAA, 16'h5555, 1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_sum", sum, 0);
      check("abort_c_out", c_out, 0);
      check("abort_ovf", overflow, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (STEPS + 2) begin
         @(negedge clk);
         check("abort_no_done", done, 0);
      end
      launch(16'h1234, 16'h1111, 1'b0, 1'b0);
      op_check(16'h2345, 1'b0, 1'b0, 0);
      post_check(16'h2345, 1'b0, 1'b0);

      // Random sweep against the integer model
      for (int n = 0; n < 1000; n++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom);
         rc = 1'($urandom);
         if (n % 16 == 0) ra = 16'h8000 ^ rb;
         model(ra, rb, rs, rc, es, eco, eov);
         launch(ra, rb, rs, rc);
         op_check(es, eco, eov, 0);
         post_check(es, eco, eov);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
